// File: rtl/p405s_timer_event_gen.sv
// Timer event generator: FIT/watchdog tap edge detection, watchdog escalation strobes and the PIT decrementer.
// Optional feature macro: P405S_PIT_AUTORELOAD_EN (adds the pitReload register and honours tcrAre).
module p405s_timer_event_gen (
  input  logic        CB,
  input  logic        resetN,
  input  logic [0:31] tbl,
  input  logic        tbTick,
  input  logic [0:1]  tcrWp,
  input  logic [0:1]  tcrWrc,
  input  logic [0:1]  tcrFp,
  input  logic        tcrAre,
  input  logic        pitWrite,
  input  logic [0:31] pitWrData,
  input  logic [0:3]  tsrState,
  output logic        wdPulse,
  output logic        hwSetWdIntrp,
  output logic        hwSetWdRst,
  output logic [0:1]  wdRstType,
  output logic        hwSetFitStatus,
  output logic        hwSetPitStatus,
  output logic [0:31] pitValue
);

  logic        fitTap;
  logic        wdTap;
  logic        fitPrev;
  logic        wdPrev;
  logic        fitEvent;
  logic        wdEvent;
  logic        wdIntrpNext;
  logic        wdRstNext;
  logic        tsrEnw;
  logic        tsrWis;
  logic [0:1]  tsrWrs;
  logic [0:31] pitNext;
  logic        pitEventNext;
  logic [0:31] reloadValue;
  logic        unusedTbl;

  // Only a handful of time base bits feed the taps; the rest are sunk here.
  assign unusedTbl = ^tbl;

  // FIT and watchdog tap multiplexers.
  always_comb begin
    fitTap = 1'b0;
    wdTap  = 1'b0;
    case (tcrFp)
      2'b00:   fitTap = tbl[23];
      2'b01:   fitTap = tbl[19];
      2'b10:   fitTap = tbl[15];
      2'b11:   fitTap = tbl[11];
      default: fitTap = 1'b0;
    endcase
    case (tcrWp)
      2'b00:   wdTap = tbl[15];
      2'b01:   wdTap = tbl[11];
      2'b10:   wdTap = tbl[7];
      2'b11:   wdTap = tbl[3];
      default: wdTap = 1'b0;
    endcase
  end

  assign fitEvent = fitTap & ~fitPrev;
  assign wdEvent  = wdTap & ~wdPrev;

  assign tsrEnw = tsrState[0];
  assign tsrWis = tsrState[1];
  assign tsrWrs = tsrState[2:3];

  // Escalation: a reset is only requested once WIS is pending and WRS is still clear.
  assign wdIntrpNext = wdEvent & tsrEnw;
  assign wdRstNext   = wdEvent & tsrEnw & tsrWis & (tcrWrc != 2'b00) & (tsrWrs == 2'b00);

`ifdef P405S_PIT_AUTORELOAD_EN
  logic [0:31] pitReload;

  assign reloadValue = tcrAre ? pitReload : 32'd0;

  // Reload value shadows every PIT write.
  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      pitReload <= 32'd0;
    end else if (pitWrite) begin
      pitReload <= pitWrData;
    end
  end
`else
  logic unusedAre;

  assign unusedAre   = tcrAre;
  assign reloadValue = 32'd0;
`endif

  // PIT next value: a write wins over a decrement; zero is sticky without reload.
  always_comb begin
    pitNext      = pitValue;
    pitEventNext = 1'b0;
    if (pitWrite) begin
      pitNext = pitWrData;
    end else if (tbTick && (pitValue != 32'd0)) begin
      if (pitValue == 32'd1) begin
        pitEventNext = 1'b1;
        pitNext      = reloadValue;
      end else begin
        pitNext = pitValue - 32'd1;
      end
    end else begin
      pitNext = pitValue;
    end
  end

  // Tap history, registered strobes and PIT state.
  always_ff @(posedge CB or negedge resetN) begin
    if (!resetN) begin
      fitPrev        <= 1'b1;
      wdPrev         <= 1'b1;
      hwSetFitStatus <= 1'b0;
      wdPulse        <= 1'b0;
      hwSetWdIntrp   <= 1'b0;
      hwSetWdRst     <= 1'b0;
      wdRstType      <= 2'b00;
      hwSetPitStatus <= 1'b0;
      pitValue       <= 32'd0;
    end else begin
      fitPrev        <= fitTap;
      wdPrev         <= wdTap;
      hwSetFitStatus <= fitEvent;
      wdPulse        <= wdEvent;
      hwSetWdIntrp   <= wdIntrpNext;
      hwSetWdRst     <= wdRstNext;
      if (wdRstNext) begin
        wdRstType <= tcrWrc;
      end
      hwSetPitStatus <= pitEventNext;
      pitValue       <= pitNext;
    end
  end

endmodule
